// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every combination of an N_IN-bit input vector into two implementations
// of the same logic function: a sum-of-products (SOP) and a product-of-sums (POS)
// gate-level block. It samples both outputs once each vector has settled, and
// records the SOP truth table. It also counts the vectors where the two outputs
// disagree and reports the lowest such vector. Each start request runs one sweep.
//
// Parameters
//   N_IN    number of function inputs (2..6)
//   SETTLE  cycles each vector is held before it is sampled (>=1)
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   start        sweep request, accepted only in IDLE once done has dropped
//   f_sop        SOP implementation output
//   f_pos        POS implementation output
//   vec          current input vector (MSB is function input a)
//   busy         high while a sweep is running
//   done         single-cycle pulse when a sweep completes
//   table_out    bit k holds f_sop sampled while vec==k
//   mism_cnt     number of vectors where f_sop != f_pos
//   first_mism   lowest vector index that mismatched
//   first_valid  first_mism holds a real index
//   match        sweep finished with no mismatches
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    f_sop,
   input  logic                    f_pos,
   output logic [N_IN-1:0]         vec,
   output logic                    busy,
   output logic                    done,
   output logic [(1<<N_IN)-1:0]    table_out,
   output logic [N_IN:0]           mism_cnt,
   output logic [N_IN-1:0]         first_mism,
   output logic                    first_valid,
   output logic                    match
);

   localparam int NV = 1 << N_IN;
   // The wait counter only has to reach SETTLE-1, so it needs at least one bit.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   WAIT_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   WAIT_ONE  = CW'(1);
   localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   MISM_ONE  = (N_IN + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            stateNext_s;
   logic [CW-1:0]     waitCnt_r;
   logic [CW-1:0]     waitCntNext_s;
   logic [N_IN-1:0]   vecNext_s;
   logic              busyNext_s;
   logic              doneNext_s;
   logic [NV-1:0]     tableNext_s;
   logic [N_IN:0]     mismCntNext_s;
   logic [N_IN-1:0]   firstMismNext_s;
   logic              firstValidNext_s;
   logic              matchNext_s;
   logic              mismNow_s;

   assign mismNow_s = f_sop ^ f_pos;

   // Next-state and next-output logic for the sweep sequencer.
   always_comb begin
      stateNext_s      = state_r;
      waitCntNext_s    = waitCnt_r;
      vecNext_s        = vec;
      busyNext_s       = busy;
      doneNext_s       = 1'b0;
      tableNext_s      = table_out;
      mismCntNext_s    = mism_cnt;
      firstMismNext_s  = first_mism;
      firstValidNext_s = first_valid;
      matchNext_s      = match;

      case (state_r)
         ST_IDLE: begin
            // While done is still high the FSM is already back in IDLE, but a
            // start in that cycle must not launch a new sweep.
            if (start && !done) begin
               vecNext_s        = {N_IN{1'b0}};
               waitCntNext_s    = {CW{1'b0}};
               tableNext_s      = {NV{1'b0}};
               mismCntNext_s    = {(N_IN + 1){1'b0}};
               firstMismNext_s  = {N_IN{1'b0}};
               firstValidNext_s = 1'b0;
               matchNext_s      = 1'b0;
               busyNext_s       = 1'b1;
               stateNext_s      = ST_WAIT;
            end else begin
               stateNext_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            if (waitCnt_r == WAIT_LAST) begin
               stateNext_s = ST_SAMPLE;
            end else begin
               waitCntNext_s = waitCnt_r + WAIT_ONE;
            end
         end

         ST_SAMPLE: begin
            tableNext_s[vec] = f_sop;
            if (mismNow_s) begin
               mismCntNext_s = mism_cnt + MISM_ONE;
            end else begin
               mismCntNext_s = mism_cnt;
            end
            if (mismNow_s && !first_valid) begin
               firstMismNext_s  = vec;
               firstValidNext_s = 1'b1;
            end else begin
               firstValidNext_s = first_valid;
            end
            if (vec != VEC_LAST) begin
               vecNext_s     = vec + VEC_ONE;
               waitCntNext_s = {CW{1'b0}};
               stateNext_s   = ST_WAIT;
            end else begin
               // The match flag must include the sample taken on this edge.
               busyNext_s  = 1'b0;
               doneNext_s  = 1'b1;
               matchNext_s = (mismCntNext_s == {(N_IN + 1){1'b0}});
               stateNext_s = ST_IDLE;
            end
         end

         default: begin
            busyNext_s  = 1'b0;
            stateNext_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over any sweep activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         waitCnt_r   <= {CW{1'b0}};
         vec         <= {N_IN{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         table_out   <= {NV{1'b0}};
         mism_cnt    <= {(N_IN + 1){1'b0}};
         first_mism  <= {N_IN{1'b0}};
         first_valid <= 1'b0;
         match       <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         waitCnt_r   <= waitCntNext_s;
         vec         <= vecNext_s;
         busy        <= busyNext_s;
         done        <= doneNext_s;
         table_out   <= tableNext_s;
         mism_cnt    <= mismCntNext_s;
         first_mism  <= firstMismNext_s;
         first_valid <= firstValidNext_s;
         match       <= matchNext_s;
      end
   end

endmodule
